clkdiv_seq_ctrl: RTL and testbench

//  Start-up and calibration sequencer for the fabric CLKDIV divide-by-4 primitive. Holds the divider in reset until
//  the upstream PLL lock is stable, releases it, then flags downstream logic after a settle period.

---
 rtl/clkdiv_seq_pkg.sv | 15 +
 rtl/sync_2ff.sv | 29 ++
 rtl/clkdiv_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_clkdiv_seq_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_seq_pkg.sv
// Shared types for the CLKDIV start-up / calibration sequencer.
// The state encoding is fixed at 3 bits so it can be probed easily on a logic analyser.
package clkdiv_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_LOCKWAIT = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_READY    = 3'd3,
        ST_CPULSE   = 3'd4,
        ST_CGAP     = 3'd5,
        ST_CACK     = 3'd6
    } seq_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser with asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/clkdiv_seq_ctrl.sv
// Start-up and calibration sequencer for the CLKDIV divide-by-4 primitive: waits for a stable
// PLL lock, releases the divider, flags clk_ready, then serves 4-phase CALIB requests.
module clkdiv_seq_ctrl
    import clkdiv_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int SETTLE_CYCLES      = 16,
    parameter int CALIB_PULSE_CYCLES = 2,
    parameter int CALIB_GAP_CYCLES   = 8,
    parameter int CNT_W              = 9
) (
    input  logic hclkin,
    input  logic resetn,
    input  logic pll_lock,
    input  logic calib_req,
    output logic calib_ack,
    output logic div_resetn,
    output logic div_calib,
    output logic clk_ready
);

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(CALIB_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(CALIB_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic lock_s;

    sync_2ff u_lock_sync (
        .clk   (hclkin),
        .rst_n (resetn),
        .d     (pll_lock),
        .q     (lock_s)
    );

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_resetn_q, div_resetn_d;
    logic             div_calib_q, div_calib_d;
    logic             clk_ready_q, clk_ready_d;
    logic             calib_ack_q, calib_ack_d;

    // Lock loss outranks every other transition; the case below only runs while lock_s is held.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_resetn_d = div_resetn_q;
        div_calib_d  = div_calib_q;
        clk_ready_d  = clk_ready_q;
        calib_ack_d  = calib_ack_q;

        if (!lock_s && state_q != ST_HOLD) begin
            state_d      = ST_HOLD;
            cnt_d        = '0;
            div_resetn_d = 1'b0;
            div_calib_d  = 1'b0;
            clk_ready_d  = 1'b0;
            calib_ack_d  = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    cnt_d        = '0;
                    div_resetn_d = 1'b0;
                    div_calib_d  = 1'b0;
                    clk_ready_d  = 1'b0;
                    calib_ack_d  = 1'b0;
                    if (lock_s) begin
                        state_d = ST_LOCKWAIT;
                    end
                end
                ST_LOCKWAIT: begin
                    if (cnt_q == LOCK_LAST) begin
                        state_d      = ST_SETTLE;
                        div_resetn_d = 1'b1;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d     = ST_READY;
                        clk_ready_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_READY: begin
                    cnt_d = '0;
                    if (calib_req && !calib_ack_q) begin
                        state_d     = ST_CPULSE;
                        div_calib_d = 1'b1;
                    end
                end
                ST_CPULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_d     = ST_CGAP;
                        div_calib_d = 1'b0;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_CGAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d     = ST_CACK;
                        calib_ack_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_CACK: begin
                    cnt_d = '0;
                    if (!calib_req) begin
                        state_d     = ST_READY;
                        calib_ack_d = 1'b0;
                    end
                end
                default: begin
                    state_d      = ST_HOLD;
                    cnt_d        = '0;
                    div_resetn_d = 1'b0;
                    div_calib_d  = 1'b0;
                    clk_ready_d  = 1'b0;
                    calib_ack_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            div_resetn_q <= 1'b0;
            div_calib_q  <= 1'b0;
            clk_ready_q  <= 1'b0;
            calib_ack_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_resetn_q <= div_resetn_d;
            div_calib_q  <= div_calib_d;
            clk_ready_q  <= clk_ready_d;
            calib_ack_q  <= calib_ack_d;
        end
    end

    assign div_resetn = div_resetn_q;
    assign div_calib  = div_calib_q;
    assign clk_ready  = clk_ready_q;
    assign calib_ack  = calib_ack_q;

endmodule

// File: tb/tb_clkdiv_seq_ctrl.sv
// Directed bench for clkdiv_seq_ctrl with short counts (lock 8, settle 4, pulse 2, gap 3).
// Edge indices count rising edges after resetn is released, starting from 0.
module tb_clkdiv_seq_ctrl;

    logic hclkin = 1'b0;
    logic resetn;
    logic pll_lock;
    logic calib_req;
    logic calib_ack;
    logic div_resetn;
    logic div_calib;
    logic clk_ready;

    int total = 0;
    int bad   = 0;

    clkdiv_seq_ctrl #(
        .LOCK_STABLE_CYCLES (8),
        .SETTLE_CYCLES      (4),
        .CALIB_PULSE_CYCLES (2),
        .CALIB_GAP_CYCLES   (3),
        .CNT_W              (9)
    ) dut (
        .hclkin     (hclkin),
        .resetn     (resetn),
        .pll_lock   (pll_lock),
        .calib_req  (calib_req),
        .calib_ack  (calib_ack),
        .div_resetn (div_resetn),
        .div_calib  (div_calib),
        .clk_ready  (clk_ready)
    );

    always #5 hclkin = ~hclkin;

    task automatic checkOutput(input string tag, input logic signed [31:0] got,
                               input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclkin);
        #1;
    endtask

    task automatic applyStimulus(input logic lock, input logic req);
        pll_lock  = lock;
        calib_req = req;
    endtask

    task automatic do_reset(input logic req);
        applyStimulus(1'b1, req);
        resetn = 1'b0;
        tick();
        tick();
        checkOutput("rst_div_resetn", div_resetn, 0);
        checkOutput("rst_div_calib", div_calib, 0);
        checkOutput("rst_clk_ready", clk_ready, 0);
        checkOutput("rst_calib_ack", calib_ack, 0);
        resetn = 1'b1;
    endtask

    // Runs 40 edges from reset release; pll_lock is low only during the cycle before drop_edge.
    task automatic measure_startup(input int drop_edge, input logic req,
                                   output int rst_rise, output int rdy_rise,
                                   output int cal_rise, output int pulses);
        logic prev_cal;
        rst_rise = -1;
        rdy_rise = -1;
        cal_rise = -1;
        pulses   = 0;
        prev_cal = div_calib;
        for (int i = 0; i < 40; i++) begin
            applyStimulus((i == drop_edge) ? 1'b0 : 1'b1, req);
            tick();
            if (div_resetn && rst_rise < 0) rst_rise = i;
            if (clk_ready && rdy_rise < 0) rdy_rise = i;
            if (div_calib && !prev_cal) begin
                pulses++;
                if (cal_rise < 0) cal_rise = i;
            end
            prev_cal = div_calib;
        end
    endtask

    task automatic count_pulses(input int n, output int pulses);
        logic prev_cal;
        pulses   = 0;
        prev_cal = div_calib;
        for (int i = 0; i < n; i++) begin
            tick();
            if (div_calib && !prev_cal) pulses++;
            prev_cal = div_calib;
        end
    endtask

    initial begin
        int rst_rise, rdy_rise, cal_rise, pulses;
        logic [7:0] cal_hist, ack_hist;

        resetn = 1'b0;
        applyStimulus(1'b1, 1'b0);

        // Clean start-up with lock already present.
        do_reset(1'b0);
        measure_startup(-1, 1'b0, rst_rise, rdy_rise, cal_rise, pulses);
        checkOutput("startup_div_resetn_edge", rst_rise, 10);
        checkOutput("startup_clk_ready_edge", rdy_rise, 14);
        checkOutput("startup_no_calib", pulses, 0);

        // One calibration: 2 high, 3 low, then ack until req drops.
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            cal_hist[i] = div_calib;
            ack_hist[i] = calib_ack;
        end
        checkOutput("calib_pulse_shape", cal_hist, 8'b0000_0011);
        checkOutput("calib_ack_shape", ack_hist, 8'b1110_0000);
        checkOutput("calib_clk_ready_kept", clk_ready, 1);
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("calib_ack_clear", calib_ack, 0);
        checkOutput("calib_idle_low", div_calib, 0);

        // A long request produces a single pulse; a re-toggle is needed for another.
        applyStimulus(1'b1, 1'b1);
        count_pulses(50, pulses);
        checkOutput("long_req_one_pulse", pulses, 1);
        checkOutput("long_req_ack_held", calib_ack, 1);
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("long_req_ack_clear", calib_ack, 0);
        applyStimulus(1'b1, 1'b1);
        tick();
        checkOutput("retoggle_pulse_start", div_calib, 1);

        // Request withdrawn mid-pulse: sequence still completes, ack shows for one cycle.
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            ack_hist[i] = calib_ack;
        end
        checkOutput("early_drop_ack_shape", ack_hist, 8'b0001_0000);

        // Lock loss during a calibration pulse.
        applyStimulus(1'b1, 1'b1);
        tick();
        checkOutput("lockloss_in_cpulse", div_calib, 1);
        applyStimulus(1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("lockloss_div_calib", div_calib, 0);
        checkOutput("lockloss_clk_ready", clk_ready, 0);
        checkOutput("lockloss_div_resetn", div_resetn, 0);
        checkOutput("lockloss_calib_ack", calib_ack, 0);

        // Lock glitch while counting: the full lock count restarts.
        do_reset(1'b0);
        measure_startup(6, 1'b0, rst_rise, rdy_rise, cal_rise, pulses);
        checkOutput("glitch_div_resetn_edge", rst_rise, 17);
        checkOutput("glitch_clk_ready_edge", rdy_rise, 21);

        // Asynchronous reset in the middle of a pulse clears outputs before the next edge.
        applyStimulus(1'b1, 1'b1);
        tick();
        checkOutput("async_pre_calib", div_calib, 1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async_div_calib", div_calib, 0);
        checkOutput("async_clk_ready", clk_ready, 0);
        checkOutput("async_div_resetn", div_resetn, 0);

        // Request raised before ready is served exactly once after READY.
        do_reset(1'b1);
        measure_startup(-1, 1'b1, rst_rise, rdy_rise, cal_rise, pulses);
        checkOutput("early_req_div_resetn_edge", rst_rise, 10);
        checkOutput("early_req_clk_ready_edge", rdy_rise, 14);
        checkOutput("early_req_calib_edge", cal_rise, 15);
        checkOutput("early_req_one_pulse", pulses, 1);
        checkOutput("early_req_ack", calib_ack, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
